controle_ventoinha_niveis: RTL and testbench
============================================

# controle_ventoinha_niveis

Parametrised fan-control datapath block. It merges temperature-level classification and fan PWM generation into one unit with N configurable levels, hysteresis on the downward path, non-monotonic-threshold detection with a fail-safe to maximum cooling, and a rate-limited duty-cycle ramp. It sits in the climate datapath between the DHT11 measurement interface and the configuration manager (source of thresholds) on one side, and the fan driver pin on the other.

## Interface
- NIVEIS, 8: number of fan levels, ≥2; NIVEIS-1 thresholds.
- LARGURA, 16: width of temperature and threshold words (unsigned).
- HISTERESE, 1: downward hysteresis, in temperature LSBs.
- PERIODO_PWM, 2000: PWM period in clocks.
- RAMPA_CICLOS, 1000: clocks per ±1 duty step, ≥1.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- temp  in  LARGURA  latest measured temperature.
- temp_valida  in  1  one-cycle strobe: temp and lim are valid.
- lim  in  LARGURA*(NIVEIS-1)  packed thresholds; lim_i = lim[i*LARGURA-1 -: LARGURA], i=1..NIVEIS-1, ascending expected.
- nivel  out  $clog2(NIVEIS)  current level.
- erro_lim  out  1  thresholds non-monotonic at last strobe.
- duty_atual  out  $clog2(PERIODO_PWM+1)  current ramped duty, in clocks.
- em_rampa  out  1  ramp in progress.
- pwm_ventoinha  out  1  fan PWM.

## Operation
- Reset (reset=0 at an edge): nivel=0, erro_lim=0, duty_atual=0, applied duty=0, PWM counter=0, prescaler=0, FSM=PARADO, pwm_ventoinha=0. Reset has priority over all events, including mid-ramp.
- On a temp_valida edge:
  - U = #{i : temp ≥ lim_i}.
  - D = #{i : temp + HISTERESE ≥ lim_i}. Computed in LARGURA+1 bits, with no wrap at temp near max.
  - If some lim_i > lim_{i+1}: erro_lim←1 and nivel←NIVEIS-1.
  - Else: erro_lim←0. If U > nivel, nivel←U; else if D < nivel, nivel←D; else nivel is unchanged.
  - Equal adjacent thresholds are legal.
- Without temp_valida, nivel and erro_lim hold.
- duty_alvo = nivel*(PERIODO_PWM/(NIVEIS-1)), integer division. For nivel=NIVEIS-1, duty_alvo = PERIODO_PWM exactly.
- Ramp FSM (registered):
  - PARADO → SUBINDO if duty_atual < duty_alvo; → DESCENDO if duty_atual > duty_alvo; prescaler held at 0.
  - SUBINDO / DESCENDO: prescaler increments each clock. When prescaler = RAMPA_CICLOS-1: duty_atual ±1 and prescaler←0.
  - Return to PARADO on the edge duty_atual reaches duty_alvo.
  - If duty_alvo crosses to the other side of duty_atual mid-ramp: switch direction directly, prescaler←0.
  - em_rampa = (FSM ≠ PARADO).
- PWM:
  - Counter runs 0..PERIODO_PWM-1 and wraps.
  - Applied duty is loaded from duty_atual only on the wrap edge, so the period is glitch-free.
  - pwm_ventoinha = registered (counter < applied duty). Duty 0 gives constant low; duty PERIODO_PWM gives constant high.

## Timing
- temp_valida sampled at edge E0: nivel/erro_lim are valid after E0, so latency is 1 clock.
- FSM leaves PARADO at E0+1. The first duty step lands at edge E0+1+RAMPA_CICLOS; each further step follows every RAMPA_CICLOS clocks.
- Full 0→PERIODO_PWM sweep takes PERIODO_PWM*RAMPA_CICLOS clocks, plus the entry cycle.
- A new duty_atual reaches the pin at the next PWM wrap, plus 1 clock (registered output).
- temp_valida during a ramp: nivel updates normally; the ramp retargets without restarting if the direction is unchanged (prescaler not cleared).
- temp_valida held high for multiple clocks: re-evaluated every clock. This is legal and idempotent for stable inputs.

## Test plan
Bench parameters: NIVEIS=4, LARGURA=8, HISTERESE=2, PERIODO_PWM=12, RAMPA_CICLOS=2, lim=(20,25,30).
- Reset: drive reset=0 for 3 clocks, then release → all outputs 0; pwm stays low for 3 PWM periods.
- Up-ramp: temp=27 strobe → nivel=2 next clock; duty_alvo=8; duty_atual steps 0→8, one step per 2 clocks; em_rampa=1 throughout, then 0. Afterwards, each 12-clock period has exactly 8 high clocks.
- Hysteresis from nivel 2:
  - temp=24 → nivel stays 2 (U=1, D=2).
  - temp=22 → nivel=1, duty ramps down to 4.
  - temp=31 → nivel=3; duty reaches 12; pwm constant high.
- Fault: lim=(20,35,30), temp=10 → erro_lim=1, nivel=3, duty→12. Then restore lim=(20,25,30), temp=10 → erro_lim=0, nivel=0, duty→0.
- Reversal and reset mid-ramp:
  - At duty_atual=5 during a 0→8 ramp, strobe temp=0 → DESCENDO next clock, prescaler restarts, duty falls to 0 with no overshoot past 5.
  - reset=0 mid-ramp → all outputs 0 at that edge.
- Overflow: temp=255, lim=(250,253,254), HISTERESE=2 → U=3, nivel=3, with no wrap in D.

Source files
------------

// File: rtl/controle_ventoinha_niveis.sv
// Fan controller: classifies temperature into N levels with downward hysteresis and drives
// a PWM pin whose duty ramps toward the level target at a bounded rate.
module controle_ventoinha_niveis #(
  parameter int unsigned NIVEIS       = 8,
  parameter int unsigned LARGURA      = 16,
  parameter int unsigned HISTERESE    = 1,
  parameter int unsigned PERIODO_PWM  = 2000,
  parameter int unsigned RAMPA_CICLOS = 1000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [LARGURA-1:0]                 temp,
  input  logic                               temp_valida,
  input  logic [LARGURA*(NIVEIS-1)-1:0]      lim,
  output logic [$clog2(NIVEIS)-1:0]          nivel,
  output logic                               erro_lim,
  output logic [$clog2(PERIODO_PWM+1)-1:0]   duty_atual,
  output logic                               em_rampa,
  output logic                               pwm_ventoinha
);

  localparam int unsigned NW    = $clog2(NIVEIS);
  localparam int unsigned DW    = $clog2(PERIODO_PWM + 1);
  localparam int unsigned LH    = LARGURA + 1;
  localparam int unsigned PW    = (RAMPA_CICLOS > 1) ? $clog2(RAMPA_CICLOS) : 1;
  localparam int unsigned NLIM  = NIVEIS - 1;
  localparam int unsigned PASSO = PERIODO_PWM / NLIM;

  localparam logic [NW-1:0] NivelMax  = NW'(NIVEIS - 1);
  localparam logic [DW-1:0] DutyMax   = DW'(PERIODO_PWM);
  localparam logic [DW-1:0] PassoD    = DW'(PASSO);
  localparam logic [DW-1:0] ContFim   = DW'(PERIODO_PWM - 1);
  localparam logic [PW-1:0] PrescFim  = PW'(RAMPA_CICLOS - 1);
  localparam logic [LH-1:0] HistExt   = LH'(HISTERESE);

  typedef enum logic [1:0] {StParado, StSubindo, StDescendo} estado_e;

  // ---------------------------------------------------------------------------------------
  // Level classification
  // ---------------------------------------------------------------------------------------
  logic [LARGURA-1:0] lim_v [NLIM];

  for (genvar g = 0; g < NLIM; g++) begin : g_lim
    assign lim_v[g] = lim[g*LARGURA +: LARGURA];
  end

  logic [NW-1:0] nivel_q, nivel_d;
  logic          erro_q, erro_d;
  logic [NW-1:0] cnt_sobe, cnt_desce;
  logic [LH-1:0] temp_h;
  logic          lim_invalido;

  // Hysteresis sum is one bit wider so temperatures near full scale never wrap.
  always_comb begin
    cnt_sobe     = '0;
    cnt_desce    = '0;
    lim_invalido = 1'b0;
    temp_h       = {1'b0, temp} + HistExt;
    for (int i = 0; i < NLIM; i++) begin
      if (temp >= lim_v[i]) begin
        cnt_sobe = cnt_sobe + NW'(1);
      end
      if (temp_h >= {1'b0, lim_v[i]}) begin
        cnt_desce = cnt_desce + NW'(1);
      end
    end
    for (int i = 0; i + 1 < NLIM; i++) begin
      if (lim_v[i] > lim_v[i+1]) begin
        lim_invalido = 1'b1;
      end
    end
  end

  always_comb begin
    nivel_d = nivel_q;
    erro_d  = erro_q;
    if (temp_valida) begin
      if (lim_invalido) begin
        erro_d  = 1'b1;
        nivel_d = NivelMax;
      end else begin
        erro_d = 1'b0;
        if (cnt_sobe > nivel_q) begin
          nivel_d = cnt_sobe;
        end else if (cnt_desce < nivel_q) begin
          nivel_d = cnt_desce;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      nivel_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      nivel_q <= nivel_d;
      erro_q  <= erro_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Duty ramp
  // ---------------------------------------------------------------------------------------
  logic [DW-1:0] duty_alvo;
  logic [DW-1:0] duty_q, duty_d;
  logic [PW-1:0] presc_q, presc_d;
  estado_e       estado_q, estado_d;

  // Top level maps to the full period so integer division never leaves the fan short.
  always_comb begin
    if (nivel_q == NivelMax) begin
      duty_alvo = DutyMax;
    end else begin
      duty_alvo = DW'(nivel_q) * PassoD;
    end
  end

  always_comb begin
    estado_d = estado_q;
    presc_d  = presc_q;
    duty_d   = duty_q;
    unique case (estado_q)
      StParado: begin
        presc_d = '0;
        if (duty_q < duty_alvo) begin
          estado_d = StSubindo;
        end else if (duty_q > duty_alvo) begin
          estado_d = StDescendo;
        end
      end
      StSubindo: begin
        if (duty_alvo < duty_q) begin
          estado_d = StDescendo;
          presc_d  = '0;
        end else if (duty_alvo == duty_q) begin
          estado_d = StParado;
          presc_d  = '0;
        end else if (presc_q == PrescFim) begin
          duty_d  = duty_q + DW'(1);
          presc_d = '0;
          if (duty_d == duty_alvo) begin
            estado_d = StParado;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StDescendo: begin
        if (duty_alvo > duty_q) begin
          estado_d = StSubindo;
          presc_d  = '0;
        end else if (duty_alvo == duty_q) begin
          estado_d = StParado;
          presc_d  = '0;
        end else if (presc_q == PrescFim) begin
          duty_d  = duty_q - DW'(1);
          presc_d = '0;
          if (duty_d == duty_alvo) begin
            estado_d = StParado;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        estado_d = StParado;
        presc_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= StParado;
      presc_q  <= '0;
      duty_q   <= '0;
    end else begin
      estado_q <= estado_d;
      presc_q  <= presc_d;
      duty_q   <= duty_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // PWM generator
  // ---------------------------------------------------------------------------------------
  logic [DW-1:0] cont_q;
  logic [DW-1:0] aplic_q;
  logic          pwm_q;

  // Applied duty only changes at the wrap so each period is either old or new, never mixed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cont_q  <= '0;
      aplic_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= (cont_q < aplic_q);
      if (cont_q == ContFim) begin
        cont_q  <= '0;
        aplic_q <= duty_q;
      end else begin
        cont_q <= cont_q + DW'(1);
      end
    end
  end

  assign nivel         = nivel_q;
  assign erro_lim      = erro_q;
  assign duty_atual    = duty_q;
  assign em_rampa      = (estado_q != StParado);
  assign pwm_ventoinha = pwm_q;

endmodule

// File: tb/tb_controle_ventoinha_niveis.sv
// Bench for controle_ventoinha_niveis: directed scenarios plus randomized strobes checked
// against an integer behavioural model of levels and ramp.
module tb_controle_ventoinha_niveis;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int H  = 2;
  localparam int P  = 12;
  localparam int R  = 2;
  localparam int NW = $clog2(N);
  localparam int DW = $clog2(P + 1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [L-1:0]         temp = '0;
  logic                 temp_valida = 1'b0;
  logic [L*(N-1)-1:0]   lim = '0;
  logic [NW-1:0]        nivel;
  logic                 erro_lim;
  logic [DW-1:0]        duty_atual;
  logic                 em_rampa;
  logic                 pwm_ventoinha;

  int lim_arr [N-1];
  int n_checks = 0;
  int n_fail = 0;

  // Model state
  int m_nivel = 0;
  bit m_erro = 1'b0;
  int m_duty = 0;
  bit m_mov = 1'b0;
  int m_dir = 0;
  int m_timer = 0;

  controle_ventoinha_niveis #(
    .NIVEIS(N), .LARGURA(L), .HISTERESE(H), .PERIODO_PWM(P), .RAMPA_CICLOS(R)
  ) dut (
    .clock(clock), .reset(reset), .temp(temp), .temp_valida(temp_valida), .lim(lim),
    .nivel(nivel), .erro_lim(erro_lim), .duty_atual(duty_atual), .em_rampa(em_rampa),
    .pwm_ventoinha(pwm_ventoinha)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int alvo(input int n);
    return (n == N - 1) ? P : n * (P / (N - 1));
  endfunction

  // Model: duty walks one unit toward the target every R clocks of continuous motion in
  // one direction; motion starts one clock after the target differs.
  always @(posedge clock) begin
    int tgt, dn, u, d;
    bit bad;
    if (!reset) begin
      m_nivel = 0; m_erro = 0; m_duty = 0; m_mov = 0; m_dir = 0; m_timer = 0;
    end else begin
      tgt = alvo(m_nivel);
      dn = (tgt > m_duty) ? 1 : ((tgt < m_duty) ? -1 : 0);
      if (dn == 0) begin
        m_mov = 0; m_timer = 0;
      end else if (!m_mov || dn != m_dir) begin
        m_mov = 1; m_dir = dn; m_timer = 0;
      end else begin
        m_timer++;
        if (m_timer == R) begin
          m_timer = 0;
          m_duty += m_dir;
          if (m_duty == tgt) m_mov = 0;
        end
      end
      if (temp_valida) begin
        bad = 0;
        for (int i = 0; i + 1 < N - 1; i++) if (lim_arr[i] > lim_arr[i+1]) bad = 1;
        if (bad) begin
          m_erro = 1; m_nivel = N - 1;
        end else begin
          u = 0; d = 0;
          for (int i = 0; i < N - 1; i++) begin
            if (int'(temp) >= lim_arr[i]) u++;
            if (int'(temp) + H >= lim_arr[i]) d++;
          end
          m_erro = 0;
          if (u > m_nivel) m_nivel = u;
          else if (d < m_nivel) m_nivel = d;
        end
      end
    end
  end

  task automatic set_lim(input int a, input int b, input int c);
    lim_arr[0] = a; lim_arr[1] = b; lim_arr[2] = c;
    for (int i = 0; i < N - 1; i++) lim[i*L +: L] = L'(lim_arr[i]);
  endtask

  // Called at a negedge; the strobe is sampled at the next posedge, returns one negedge later.
  task automatic strobe(input int t);
    temp = L'(t);
    temp_valida = 1'b1;
    @(negedge clock);
    temp_valida = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; temp_valida = 1'b0; temp = '0;
    set_lim(20, 25, 30);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    n_checks++;
    if (nivel !== 0 || erro_lim !== 0 || duty_atual !== 0 || em_rampa !== 0
        || pwm_ventoinha !== 0) begin
      n_fail++;
      $display("FAIL reset_state: nivel=%0d erro=%b duty=%0d rampa=%b pwm=%b, required all 0",
               nivel, erro_lim, duty_atual, em_rampa, pwm_ventoinha);
    end
    for (int c = 0; c < 3 * P; c++) begin
      @(negedge clock);
      n_checks++;
      if (pwm_ventoinha !== 1'b0 || duty_atual !== '0) begin
        n_fail++;
        $display("FAIL reset_pwm_low: cycle %0d pwm=%b duty=%0d, required 0/0",
                 c, pwm_ventoinha, duty_atual);
      end
    end
  endtask

  task automatic test_up_ramp();
    bit fim = 0;
    int altos = 0;
    int prev = 0;
    strobe(27);
    n_checks++;
    if (nivel !== 2 || erro_lim !== 0 || em_rampa !== 0) begin
      n_fail++;
      $display("FAIL up_ramp_level: nivel=%0d erro=%b rampa=%b, required 2/0/0",
               nivel, erro_lim, em_rampa);
    end
    for (int c = 1; c <= 40 && !fim; c++) begin
      @(negedge clock);
      n_checks++;
      if (duty_atual !== DW'(m_duty) || em_rampa !== m_mov || int'(duty_atual) < prev) begin
        n_fail++;
        $display("FAIL up_ramp_track: cycle %0d duty=%0d rampa=%b, model duty=%0d rampa=%b",
                 c, duty_atual, em_rampa, m_duty, m_mov);
      end
      prev = int'(duty_atual);
      if (em_rampa === 1'b1) altos++;
      else if (c > 1) fim = 1;
    end
    n_checks++;
    if (!fim || altos != 8 * R || duty_atual !== 8) begin
      n_fail++;
      $display("FAIL up_ramp_done: duty=%0d ramp_cycles=%0d, required 8 and %0d",
               duty_atual, altos, 8 * R);
    end
    repeat (2 * P + 2) @(negedge clock);
    altos = 0;
    for (int c = 0; c < P; c++) begin
      @(negedge clock);
      if (pwm_ventoinha === 1'b1) altos++;
    end
    n_checks++;
    if (altos != 8) begin
      n_fail++;
      $display("FAIL up_ramp_pwm: high clocks per period=%0d, required 8", altos);
    end
  endtask

  task automatic test_hysteresis();
    bit fim = 0;
    int altos = 0;
    strobe(24);
    n_checks++;
    if (nivel !== 2) begin
      n_fail++;
      $display("FAIL hyst_hold: nivel=%0d, required 2", nivel);
    end
    repeat (4) @(negedge clock);
    n_checks++;
    if (em_rampa !== 0 || duty_atual !== 8) begin
      n_fail++;
      $display("FAIL hyst_hold_duty: duty=%0d rampa=%b, required 8/0", duty_atual, em_rampa);
    end
    strobe(22);
    n_checks++;
    if (nivel !== 1) begin
      n_fail++;
      $display("FAIL hyst_down: nivel=%0d, required 1", nivel);
    end
    for (int c = 1; c <= 30 && !fim; c++) begin
      @(negedge clock);
      n_checks++;
      if (duty_atual !== DW'(m_duty) || em_rampa !== m_mov) begin
        n_fail++;
        $display("FAIL hyst_down_track: cycle %0d duty=%0d rampa=%b, model duty=%0d rampa=%b",
                 c, duty_atual, em_rampa, m_duty, m_mov);
      end
      if (em_rampa !== 1'b1 && c > 1) fim = 1;
    end
    n_checks++;
    if (!fim || duty_atual !== 4) begin
      n_fail++;
      $display("FAIL hyst_down_done: duty=%0d, required 4", duty_atual);
    end
    repeat (2 * P + 2) @(negedge clock);
    for (int c = 0; c < P; c++) begin
      @(negedge clock);
      if (pwm_ventoinha === 1'b1) altos++;
    end
    n_checks++;
    if (altos != 4) begin
      n_fail++;
      $display("FAIL hyst_down_pwm: high clocks per period=%0d, required 4", altos);
    end
    strobe(31);
    n_checks++;
    if (nivel !== 3) begin
      n_fail++;
      $display("FAIL hyst_up: nivel=%0d, required 3", nivel);
    end
    fim = 0;
    for (int c = 1; c <= 40 && !fim; c++) begin
      @(negedge clock);
      if (em_rampa !== 1'b1 && c > 1) fim = 1;
    end
    n_checks++;
    if (!fim || duty_atual !== P) begin
      n_fail++;
      $display("FAIL hyst_up_done: duty=%0d, required %0d", duty_atual, P);
    end
    repeat (2 * P + 2) @(negedge clock);
    for (int c = 0; c < 2 * P; c++) begin
      @(negedge clock);
      n_checks++;
      if (pwm_ventoinha !== 1'b1) begin
        n_fail++;
        $display("FAIL hyst_full_pwm: cycle %0d pwm=%b, required 1", c, pwm_ventoinha);
      end
    end
  endtask

  task automatic test_fault();
    bit fim = 0;
    set_lim(20, 35, 30);
    strobe(10);
    n_checks++;
    if (erro_lim !== 1 || nivel !== 3) begin
      n_fail++;
      $display("FAIL fault_detect: erro=%b nivel=%0d, required 1/3", erro_lim, nivel);
    end
    repeat (4) @(negedge clock);
    n_checks++;
    if (duty_atual !== P || em_rampa !== 0 || erro_lim !== 1) begin
      n_fail++;
      $display("FAIL fault_hold: duty=%0d rampa=%b erro=%b, required %0d/0/1",
               duty_atual, em_rampa, erro_lim, P);
    end
    set_lim(20, 25, 30);
    strobe(10);
    n_checks++;
    if (erro_lim !== 0 || nivel !== 0) begin
      n_fail++;
      $display("FAIL fault_clear: erro=%b nivel=%0d, required 0/0", erro_lim, nivel);
    end
    for (int c = 1; c <= 40 && !fim; c++) begin
      @(negedge clock);
      n_checks++;
      if (duty_atual !== DW'(m_duty) || em_rampa !== m_mov) begin
        n_fail++;
        $display("FAIL fault_ramp_track: cycle %0d duty=%0d rampa=%b, model duty=%0d rampa=%b",
                 c, duty_atual, em_rampa, m_duty, m_mov);
      end
      if (em_rampa !== 1'b1 && c > 1) fim = 1;
    end
    n_checks++;
    if (!fim || duty_atual !== 0) begin
      n_fail++;
      $display("FAIL fault_ramp_done: duty=%0d, required 0", duty_atual);
    end
    repeat (2 * P + 2) @(negedge clock);
    for (int c = 0; c < P; c++) begin
      @(negedge clock);
      n_checks++;
      if (pwm_ventoinha !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_pwm_low: cycle %0d pwm=%b, required 0", c, pwm_ventoinha);
      end
    end
  endtask

  task automatic test_reversal();
    bit achou = 0;
    bit fim = 0;
    strobe(27);
    for (int c = 0; c < 30 && !achou; c++) begin
      @(negedge clock);
      if (duty_atual === 5) achou = 1;
    end
    n_checks++;
    if (!achou) begin
      n_fail++;
      $display("FAIL reversal_reach5: duty=%0d, required to reach 5", duty_atual);
    end
    strobe(0);
    n_checks++;
    if (nivel !== 0 || duty_atual !== 5) begin
      n_fail++;
      $display("FAIL reversal_strobe: nivel=%0d duty=%0d, required 0/5", nivel, duty_atual);
    end
    @(negedge clock);
    n_checks++;
    if (em_rampa !== 1 || duty_atual !== 5) begin
      n_fail++;
      $display("FAIL reversal_turn: rampa=%b duty=%0d, required 1/5", em_rampa, duty_atual);
    end
    @(negedge clock);
    n_checks++;
    if (duty_atual !== 5) begin
      n_fail++;
      $display("FAIL reversal_prescaler: duty=%0d, required 5", duty_atual);
    end
    @(negedge clock);
    n_checks++;
    if (duty_atual !== 4) begin
      n_fail++;
      $display("FAIL reversal_first_step: duty=%0d, required 4", duty_atual);
    end
    for (int c = 1; c <= 20 && !fim; c++) begin
      @(negedge clock);
      n_checks++;
      if (duty_atual !== DW'(m_duty) || em_rampa !== m_mov || duty_atual > 5) begin
        n_fail++;
        $display("FAIL reversal_track: cycle %0d duty=%0d rampa=%b, model duty=%0d rampa=%b",
                 c, duty_atual, em_rampa, m_duty, m_mov);
      end
      if (em_rampa !== 1'b1) fim = 1;
    end
    n_checks++;
    if (!fim || duty_atual !== 0) begin
      n_fail++;
      $display("FAIL reversal_done: duty=%0d, required 0", duty_atual);
    end
    strobe(31);
    repeat (15) @(negedge clock);
    n_checks++;
    if (em_rampa !== 1 || duty_atual !== 7) begin
      n_fail++;
      $display("FAIL midramp_before_reset: rampa=%b duty=%0d, required 1/7", em_rampa, duty_atual);
    end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (nivel !== 0 || erro_lim !== 0 || duty_atual !== 0 || em_rampa !== 0
        || pwm_ventoinha !== 0) begin
      n_fail++;
      $display("FAIL midramp_reset: nivel=%0d erro=%b duty=%0d rampa=%b pwm=%b, required all 0",
               nivel, erro_lim, duty_atual, em_rampa, pwm_ventoinha);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (duty_atual !== 0 || em_rampa !== 0 || nivel !== 0) begin
      n_fail++;
      $display("FAIL after_reset_idle: duty=%0d rampa=%b nivel=%0d, required 0/0/0",
               duty_atual, em_rampa, nivel);
    end
  endtask

  task automatic test_overflow();
    set_lim(250, 253, 254);
    strobe(255);
    n_checks++;
    if (nivel !== 3 || erro_lim !== 0) begin
      n_fail++;
      $display("FAIL overflow_top: nivel=%0d erro=%b, required 3/0", nivel, erro_lim);
    end
    set_lim(250, 253, 255);
    strobe(254);
    n_checks++;
    if (nivel !== 3) begin
      n_fail++;
      $display("FAIL overflow_no_wrap: nivel=%0d, required 3", nivel);
    end
    strobe(249);
    n_checks++;
    if (nivel !== 1) begin
      n_fail++;
      $display("FAIL overflow_drop: nivel=%0d, required 1", nivel);
    end
  endtask

  task automatic test_back_to_back();
    set_lim(20, 25, 30);
    temp = 8'd27;
    temp_valida = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (nivel !== 2 || erro_lim !== 0) begin
        n_fail++;
        $display("FAIL held_strobe_up: cycle %0d nivel=%0d erro=%b, required 2/0",
                 c, nivel, erro_lim);
      end
    end
    temp = 8'd22;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (nivel !== 1) begin
        n_fail++;
        $display("FAIL held_strobe_down: cycle %0d nivel=%0d, required 1", c, nivel);
      end
    end
    temp_valida = 1'b0;
  endtask

  task automatic test_random();
    int v [3];
    int t, tmp, hold, gap;
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 3; i++) v[i] = int'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) begin
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2 - a; b++)
            if (v[b] > v[b+1]) begin tmp = v[b]; v[b] = v[b+1]; v[b+1] = tmp; end
        if ($urandom_range(0, 5) == 0) v[1] = v[0];
      end
      set_lim(v[0], v[1], v[2]);
      if ($urandom_range(0, 1) == 1)
        t = v[$urandom_range(0, 2)] + int'($urandom_range(0, 6)) - 3;
      else
        t = int'($urandom_range(0, 255));
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      temp = L'(t);
      temp_valida = 1'b1;
      hold = int'($urandom_range(1, 3));
      gap = int'($urandom_range(0, 12));
      for (int c = 0; c < hold + gap; c++) begin
        @(negedge clock);
        if (c == hold - 1) temp_valida = 1'b0;
        n_checks++;
        if (nivel !== NW'(m_nivel) || erro_lim !== m_erro || duty_atual !== DW'(m_duty)
            || em_rampa !== m_mov) begin
          n_fail++;
          $display("FAIL random_track: it %0d temp=%0d nivel=%0d erro=%b duty=%0d rampa=%b, model %0d/%b/%0d/%b",
                   it, t, nivel, erro_lim, duty_atual, em_rampa, m_nivel, m_erro, m_duty, m_mov);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_hysteresis();
    test_fault();
    test_reversal();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
